prog_loader: RTL
================

# prog_loader

Boot-time program loader that drives the write port of the instruction memory. It accepts a framed byte stream over a valid/ready handshake (length header, big-endian 32-bit words, XOR checksum) and writes each assembled word to consecutive instruction memory addresses starting at 0. It holds the CPU in reset while loading, then reports done or error.

## Interface

Parameters:
- DEPTH, 64, number of instruction memory words; the largest accepted word count.
- ADDR_W, 16, width of mem_addr.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready.
- mem_write  output  1  one-cycle write strobe to the instruction memory.
- mem_addr  output  ADDR_W  word address for the write.
- mem_datain  output  32  word to write.
- cpu_hold  output  1  high until a load completes successfully; drives the CPU reset.
- done  output  1  sticky; load completed with a matching checksum.
- error  output  1  sticky; oversize length or checksum mismatch.

## Operation

- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes (each word MSB first), then one checksum byte CSUM.
- CSUM is the XOR of every byte from LEN_HI through the last data byte. The running XOR is cleared by reset.
- States:
  - S_LEN_HI: accept a byte, latch count[15:8], go to S_LEN_LO.
  - S_LEN_LO: accept a byte, latch count[7:0]. If count > DEPTH, go to S_ERR. If count == 0, go to S_CSUM. Otherwise go to S_DATA.
  - S_DATA: shift each accepted byte into a 32-bit assembly register as {asm[23:0], byte}. A 2-bit byte counter tracks position in the word. When the 4th byte is accepted, present the full word and word index for the write. When the word index reaches N-1 on that write, go to S_CSUM.
  - S_CSUM: accept a byte. If it equals the running XOR, go to S_DONE. Otherwise go to S_ERR.
  - S_DONE: terminal. in_ready=0, done=1, cpu_hold=0.
  - S_ERR: terminal. in_ready=0, error=1, cpu_hold=1.
  - Both terminal states are left only by reset.
- in_ready is 1 in S_LEN_HI, S_LEN_LO, S_DATA and S_CSUM, and 0 elsewhere and during reset.
- Words that were already written before an error stay in memory. The CPU is kept held, so they are never executed.
- Word index arithmetic: the index is 16 bits wide and increments after each write. mem_addr is the index truncated or zero-extended to ADDR_W.

## Timing

- Reset values: in_ready=0, mem_write=0, mem_addr=0, mem_datain=0, cpu_hold=1, done=0, error=0, state S_LEN_HI, word index 0, running XOR 0.
- The first cycle after reset deasserts has in_ready=1.
- mem_write is high for exactly one cycle, the cycle after the 4th-byte handshake. mem_addr and mem_datain are valid in that cycle and held until the next write. mem_write is never asserted while reset is high.
- in_ready stays high through the write cycle. At most one byte is accepted per cycle, so writes are at least 4 cycles apart.
- in_valid gaps of any length stall progress without loss. in_data is ignored when in_valid=0.
- done and error assert the cycle after the deciding handshake: LEN_LO for oversize, CSUM for pass/fail. cpu_hold falls in the same cycle done rises.
- Reset mid-load returns to the reset values next cycle and discards partial word, count and XOR. A new frame must then start from LEN_HI.

## Test plan

- Frame 00 01 12 34 56 78 09 -> one write, addr 0, data 0x12345678; then done=1, cpu_hold=0, in_ready=0, error=0.
- Same frame with CSUM 0x08 -> write to addr 0 occurs; then error=1, done=0, cpu_hold=1, in_ready=0.
- Six-word frame (N=6, words 0x60418FFE..0x80860000, correct CSUM), with in_valid toggling randomly -> writes at addr 0..5 in order, each strobe one cycle wide, done=1.
- LEN = 00 41 (65 > DEPTH 64) -> no mem_write; error=1 the cycle after LEN_LO; in_ready=0; later bytes are ignored.
- LEN = 00 00, CSUM 00 -> no writes, done=1. With CSUM 01 instead -> error=1.
- Reset asserted after 2 of 4 bytes of word 1 -> outputs at reset values. A fresh frame 00 01 AA BB CC DD CSUM -> a single write of 0xAABBCCDD to addr 0, then done=1.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time loader: framed byte stream in, instruction memory writes out.
// Holds the CPU in reset until a frame with a matching checksum lands.
module prog_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_datain,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state, state_nx;
    logic        hs;
    logic        accepting;
    logic [15:0] count;
    logic [15:0] len;
    logic [15:0] widx;
    logic [23:0] asmw;
    logic [1:0]  bcnt;
    logic [7:0]  xsum;
    logic        wr_q;
    logic        last_word;

    assign hs        = in_valid & in_ready;
    assign len       = {count[15:8], in_data};
    assign last_word = (bcnt == 2'd3) && (widx == count - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) state <= S_LEN_HI;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_LEN_HI: if (hs) state_nx = S_LEN_LO;
            S_LEN_LO: begin
                if (hs) begin
                    if (len > 16'(DEPTH))  state_nx = S_ERR;
                    else if (len == 16'd0) state_nx = S_CSUM;
                    else                   state_nx = S_DATA;
                end
            end
            S_DATA:   if (hs && last_word) state_nx = S_CSUM;
            S_CSUM: begin
                if (hs) state_nx = (in_data == xsum) ? S_DONE : S_ERR;
            end
            S_DONE:   state_nx = S_DONE;
            S_ERR:    state_nx = S_ERR;
            default:  state_nx = S_LEN_HI;
        endcase
    end

    // Outputs are masked by reset so nothing leaks during the reset cycle.
    always_comb begin
        accepting = (state == S_LEN_HI) || (state == S_LEN_LO)
                 || (state == S_DATA)   || (state == S_CSUM);
        in_ready  = accepting & ~reset;
        done      = (state == S_DONE) & ~reset;
        error     = (state == S_ERR) & ~reset;
        cpu_hold  = reset | (state != S_DONE);
        mem_write = wr_q & ~reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            widx       <= '0;
            asmw       <= '0;
            bcnt       <= '0;
            xsum       <= '0;
            wr_q       <= 1'b0;
            mem_addr   <= '0;
            mem_datain <= '0;
        end else begin
            wr_q <= 1'b0;
            if (hs) begin
                case (state)
                    S_LEN_HI: begin
                        count[15:8] <= in_data;
                        xsum        <= xsum ^ in_data;
                    end
                    S_LEN_LO: begin
                        count[7:0] <= in_data;
                        xsum       <= xsum ^ in_data;
                    end
                    S_DATA: begin
                        asmw <= {asmw[15:0], in_data};
                        bcnt <= bcnt + 2'd1;
                        xsum <= xsum ^ in_data;
                        if (bcnt == 2'd3) begin
                            wr_q       <= 1'b1;
                            mem_addr   <= ADDR_W'(widx);
                            mem_datain <= {asmw, in_data};
                            widx       <= widx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
